jk_counter: RTL and testbench



---
 rtl/jk_pkg.sv | 14 +
 rtl/jk_counter_flipjk.sv | 30 +++
 rtl/jk_counter.sv | 75 +++++++
 tb/tb_jk_counter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared JK command encoding for the counter and its flip-flop cells.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package jk_pkg;

    // {J,K} command presented to one flipJK cell
    typedef logic [1:0] jk_cmd_t;

    localparam jk_cmd_t JK_HOLD = 2'b00;
    localparam jk_cmd_t JK_RST  = 2'b01;
    localparam jk_cmd_t JK_SET  = 2'b10;
    localparam jk_cmd_t JK_TOG  = 2'b11;

endpackage

// File: rtl/jk_counter_flipjk.sv
// Single JK flip-flop cell with enable; holds one bit of counter state.
// Latency: Q updates on the rising CLK edge after J/K are presented.
// Backpressure: none; EN low freezes the cell.
module flipJK
    import jk_pkg::*;
(
    input  logic CLK,
    input  logic RESET,
    input  logic EN,
    input  logic J,
    input  logic K,
    output logic Q
);

    // JK state update: hold / reset / set / toggle, async clear on RESET
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            Q <= 1'b0;
        end else if (EN) begin
            case (jk_cmd_t'({J, K}))
                JK_HOLD: Q <= Q;
                JK_RST:  Q <= 1'b0;
                JK_SET:  Q <= 1'b1;
                JK_TOG:  Q <= ~Q;
                default: Q <= Q;
            endcase
        end
    end

endmodule

// File: rtl/jk_counter.sv
// Modulo-MODULUS up/down counter with clamped parallel load, state held in flipJK cells.
// Latency: Q follows the command one CLK edge later; TC is combinational; WRAP lags TC by one edge.
// Backpressure: none; EN low holds the count, LOAD overrides EN.
module jk_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             WRAP
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
    // one extra bit so MODULUS == 2**WIDTH is still representable
    localparam logic [WIDTH:0]   MODW = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0]    nxt;
    logic [WIDTH-1:0]    tog;
    jk_cmd_t [WIDTH-1:0] cmd;

    // Next count: LOAD (clamped) beats EN, EN beats hold; the boundary test comes
    // before the +/-1 so no out-of-range value is produced, and any stray
    // out-of-range state recovers to 0 on the next up-count.
    always_comb begin
        nxt = Q;
        if (LOAD) begin
            nxt = ({1'b0, D} < MODW) ? D : MAXV;
        end else if (EN) begin
            if (UP) begin
                nxt = (Q >= MAXV) ? '0 : Q + 1'b1;
            end else begin
                nxt = (Q == '0) ? MAXV : Q - 1'b1;
            end
        end
    end

    // Toggle encoding: only changing bits get JK=11, all others JK=00
    always_comb begin
        tog = Q ^ nxt;
        for (int i = 0; i < WIDTH; i++) begin
            cmd[i] = tog[i] ? JK_TOG : JK_HOLD;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        flipJK u_bit (
            .CLK   (CLK),
            .RESET (RESET),
            .EN    (1'b1),
            .J     (cmd[g][1]),
            .K     (cmd[g][0]),
            .Q     (Q[g])
        );
    end

    assign TC = EN & ~LOAD & (UP ? (Q == MAXV) : (Q == '0));

    // Registered wrap pulse: high for the cycle after an edge taken with TC set
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            WRAP <= 1'b0;
        end else begin
            WRAP <= TC;
        end
    end

endmodule

// File: tb/tb_jk_counter.sv
// Scoreboard bench for jk_counter (WIDTH=4, MODULUS=10).
// Stimulus drives on the falling edge and queues expectations; a monitor checks.
// No backpressure: one command per cycle while cmd_vld is high.
module tb_jk_counter;
    import jk_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       EN = 1'b0;
    logic       UP = 1'b0;
    logic       LOAD = 1'b0;
    logic [3:0] D = 4'd0;
    logic [3:0] Q;
    logic       TC;
    logic       WRAP;

    typedef struct {
        int q;
        int tc;
        int wrap;
    } exp_t;

    exp_t sb[$];
    logic cmd_vld = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   mq = 0;

    jk_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .EN    (EN),
        .UP    (UP),
        .LOAD  (LOAD),
        .D     (D),
        .Q     (Q),
        .TC    (TC),
        .WRAP  (WRAP)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Behavioural modulo-10 model
    function automatic int m_next(int q, bit en, bit up, bit ld, int d);
        if (ld)      return (d < 10) ? d : 9;
        if (!en)     return q;
        if (up)      return (q == 9) ? 0 : q + 1;
        return (q == 0) ? 9 : q - 1;
    endfunction

    function automatic int m_tc(int q, bit en, bit up, bit ld);
        return (en && !ld && (up ? (q == 9) : (q == 0))) ? 1 : 0;
    endfunction

    // Apply a command now (caller is at a falling edge) and queue its expectation
    task automatic issue(input bit en, input bit up, input bit ld, input int d);
        exp_t e;
        RESET = 1'b0;
        EN = en; UP = up; LOAD = ld; D = 4'(d);
        e.tc = m_tc(mq, en, up, ld);
        e.q = m_next(mq, en, up, ld, d);
        e.wrap = e.tc;
        mq = e.q;
        sb.push_back(e);
        cmd_vld = 1'b1;
    endtask

    task automatic step(input bit en, input bit up, input bit ld, input int d);
        @(negedge CLK);
        issue(en, up, ld, d);
    endtask

    // Reset held across one rising edge, still scoreboarded
    task automatic rst_step(input bit en, input bit up, input bit ld, input int d);
        exp_t e;
        @(negedge CLK);
        RESET = 1'b1;
        EN = en; UP = up; LOAD = ld; D = 4'(d);
        mq = 0;
        e.tc = m_tc(0, en, up, ld);
        e.q = 0;
        e.wrap = 0;
        sb.push_back(e);
        cmd_vld = 1'b1;
    endtask

    task automatic idle();
        @(negedge CLK);
        cmd_vld = 1'b0;
        EN = 1'b0; LOAD = 1'b0;
    endtask

    // Monitor: sample TC and JK drive just before the edge, Q/WRAP just after
    initial begin
        int tc_s;
        logic vld_s;
        jk_cmd_t [3:0] c;
        exp_t e;
        forever begin
            @(negedge CLK);
            #4;
            vld_s = cmd_vld;
            tc_s = int'(TC);
            c = dut.cmd;
            @(posedge CLK);
            #1;
            if (vld_s) begin
                for (int i = 0; i < 4; i++)
                    chk("jk_legal", int'(c[i] == JK_RST || c[i] == JK_SET), 0);
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("tc", tc_s, e.tc);
                    chk("q", int'(Q), e.q);
                    chk("wrap", int'(WRAP), e.wrap);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        jk_cmd_t [3:0] c;
        // Reset state
        #2;
        chk("rst_q", int'(Q), 0);
        chk("rst_wrap", int'(WRAP), 0);
        chk("rst_tc", int'(TC), 0);

        // Async reset mid-cycle with Q=7, then count up from 0
        step(0, 0, 1, 7);
        @(negedge CLK);
        cmd_vld = 1'b0;
        LOAD = 1'b0;
        #2 RESET = 1'b1;
        #1;
        chk("async_rst_q", int'(Q), 0);
        chk("async_rst_wrap", int'(WRAP), 0);
        mq = 0;
        step(1, 1, 0, 0);                         // Q=1

        // Up wrap over 10 edges from 0: 1..9,0
        step(0, 0, 1, 0);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0);

        // Down wrap from 0: 9 then 8
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);

        // Load wins over EN, clamp, then hold
        step(1, 1, 1, 5);
        step(1, 0, 1, 12);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        step(1, 1, 1, 15);                        // clamp at top: TC 0 despite Q=9, UP=1

        // Drive encoding 3 -> 4
        step(0, 0, 1, 3);
        @(negedge CLK);
        issue(1, 1, 0, 0);
        #1;
        c = dut.cmd;
        chk("jk_b0", int'(c[0]), int'(JK_TOG));
        chk("jk_b1", int'(c[1]), int'(JK_TOG));
        chk("jk_b2", int'(c[2]), int'(JK_TOG));
        chk("jk_b3", int'(c[3]), int'(JK_HOLD));

        // Random mix with occasional reset
        for (int i = 0; i < 500; i++) begin
            bit en, up, ld;
            int d;
            en = ($urandom_range(3) != 0);
            up = $urandom_range(1);
            ld = ($urandom_range(7) == 0);
            d = $urandom_range(15);
            if ($urandom_range(39) == 0) rst_step(en, up, ld, d);
            else step(en, up, ld, d);
        end

        idle();
        idle();
        idle();
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
